// File: rtl/dcache_req_arbiter_pkg.sv
// Shared types for the dcache request arbiter slice.
//  XLEN         datapath / physical address width
//  TAG_W        LSU load tag width
//  inst_size_t  access size (byte, half, word, double word)
//  lsu_tag_t    tag that travels with a load and comes back with its data
//  dcache_req_t one dcache request as held in the output slot
package dcache_req_arbiter_pkg;

    localparam int XLEN  = 64;
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        SIZE_B  = 2'd0,
        SIZE_H  = 2'd1,
        SIZE_W  = 2'd2,
        SIZE_DW = 2'd3
    } inst_size_t;

    typedef logic [TAG_W-1:0] lsu_tag_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        inst_size_t      size;
        logic [XLEN-1:0] wdata;
    } dcache_req_t;

endpackage

// File: rtl/dcache_req_arbiter_tag_fifo.sv
// lsu_tag_fifo: synchronous FIFO of LSU load tags, one entry per load in flight.
//  clk, rstn  clock and asynchronous active-low reset
//  push       write push_tag (ignored when full)
//  push_tag   tag to store
//  pop        drop the head entry (ignored when empty)
//  head_tag   oldest stored tag
//  full/empty occupancy flags
module lsu_tag_fifo
    import dcache_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  lsu_tag_t push_tag,
    input  logic     pop,
    output lsu_tag_t head_tag,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    lsu_tag_t         entries [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_tag = entries[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (do_push) begin
                entries[wr_ptr[PTR_W-1:0]] <= push_tag;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: shares the single dcache request port between LSU loads
// and the store-queue drain, registers the winner into an output slot, and
// routes in-order load responses back to the LSU with their tags.
//  ld_req_*   load request from the LSU (ready = accepted this cycle)
//  st_req_*   committed store-queue head (ready = SQ pops)
//  drain_i    blocks new loads and forces stores through
//  mem_req_*  registered dcache request slot, held until mem_req_ready_i
//  mem_rsp_*  in-order load data from the dcache
//  ld_rsp_*   registered one-cycle load response to the LSU
//  idle_o     nothing in the slot, nothing outstanding, no store waiting
//  err_o      sticky: a response arrived with no load outstanding
module dcache_req_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_MAX      = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ld_req_valid_i,
    output logic            ld_req_ready_o,
    input  logic [XLEN-1:0] ld_req_addr_i,
    input  inst_size_t      ld_req_size_i,
    input  lsu_tag_t        ld_req_tag_i,
    input  logic            st_req_valid_i,
    output logic            st_req_ready_o,
    input  logic [XLEN-1:0] st_req_addr_i,
    input  inst_size_t      st_req_size_i,
    input  logic [XLEN-1:0] st_req_data_i,
    input  logic            drain_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic            mem_req_we_o,
    output logic [XLEN-1:0] mem_req_addr_o,
    output inst_size_t      mem_req_size_o,
    output logic [XLEN-1:0] mem_req_wdata_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    output logic            ld_rsp_valid_o,
    output lsu_tag_t        ld_rsp_tag_o,
    output logic [XLEN-1:0] ld_rsp_data_o,
    output logic            idle_o,
    output logic            err_o
);

    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    dcache_req_t          slot_q;
    dcache_req_t          slot_d;
    logic                 slot_valid_q;
    logic [CNT_W-1:0]     outstanding;
    logic [STARVE_W-1:0]  starve;

    logic     slot_free;
    logic     ld_ok;
    logic     force_st;
    logic     st_pick;
    logic     st_grant;
    logic     ld_grant;
    logic     rsp_accept;
    logic     rsp_orphan;
    lsu_tag_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;

    // The slot may be refilled in the same cycle the dcache takes its contents.
    // The FIFO full flag tracks the outstanding count; it is kept as a guard.
    assign slot_free  = !slot_valid_q || mem_req_ready_i;
    assign ld_ok      = ld_req_valid_i && !drain_i && !fifo_full &&
                        (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign force_st   = st_req_valid_i && ((starve == STARVE_W'(STARVE_MAX)) || drain_i);
    assign st_pick    = force_st || (st_req_valid_i && !ld_ok);
    assign st_grant   = slot_free && st_pick;
    assign ld_grant   = slot_free && !st_pick && ld_ok;

    assign ld_req_ready_o = ld_grant;
    assign st_req_ready_o = st_grant;

    // A response only counts if a load is actually waiting for it.
    assign rsp_accept = mem_rsp_valid_i && !fifo_empty;
    assign rsp_orphan = mem_rsp_valid_i && fifo_empty;

    assign mem_req_valid_o = slot_valid_q;
    assign mem_req_we_o    = slot_q.we;
    assign mem_req_addr_o  = slot_q.addr;
    assign mem_req_size_o  = slot_q.size;
    assign mem_req_wdata_o = slot_q.wdata;

    assign idle_o = !slot_valid_q && (outstanding == '0) && !st_req_valid_i;

    lsu_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (ld_grant),
        .push_tag (ld_req_tag_i),
        .pop      (mem_rsp_valid_i),
        .head_tag (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Build the request that wins this cycle; an empty slot carries zeros.
    always_comb begin
        slot_d = '0;
        if (st_grant) begin
            slot_d.we    = 1'b1;
            slot_d.addr  = st_req_addr_i;
            slot_d.size  = st_req_size_i;
            slot_d.wdata = st_req_data_i;
        end else if (ld_grant) begin
            slot_d.we    = 1'b0;
            slot_d.addr  = ld_req_addr_i;
            slot_d.size  = ld_req_size_i;
        end
    end

    // The slot only changes when its current contents have been taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
        end else if (slot_free) begin
            slot_valid_q <= st_grant || ld_grant;
            slot_q       <= slot_d;
        end
    end

    // Loads in flight, counted from grant until their response; a same-cycle
    // grant and response cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
        end else begin
            case ({ld_grant, rsp_accept})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Counts consecutive cycles a waiting store has lost; saturates so the
    // forced grant keeps firing until the store gets through.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve <= '0;
        end else if (!st_req_valid_i || st_grant) begin
            starve <= '0;
        end else if (starve != STARVE_W'(STARVE_MAX)) begin
            starve <= starve + STARVE_W'(1);
        end
    end

    // Response return path and the sticky orphan-response flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_rsp_valid_o <= 1'b0;
            ld_rsp_tag_o   <= '0;
            ld_rsp_data_o  <= '0;
            err_o          <= 1'b0;
        end else begin
            ld_rsp_valid_o <= rsp_accept;
            if (rsp_accept) begin
                ld_rsp_tag_o  <= fifo_head;
                ld_rsp_data_o <= mem_rsp_data_i;
            end
            if (rsp_orphan) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (starvation, back-pressure,
// outstanding limit, same-cycle grant/response, drain and orphan responses).
module tb_dcache_req_arbiter;
    import dcache_req_arbiter_pkg::*;

    logic            clk;
    logic            rstn;
    logic            ld_req_valid_i;
    logic            ld_req_ready_o;
    logic [XLEN-1:0] ld_req_addr_i;
    inst_size_t      ld_req_size_i;
    lsu_tag_t        ld_req_tag_i;
    logic            st_req_valid_i;
    logic            st_req_ready_o;
    logic [XLEN-1:0] st_req_addr_i;
    inst_size_t      st_req_size_i;
    logic [XLEN-1:0] st_req_data_i;
    logic            drain_i;
    logic            mem_req_valid_o;
    logic            mem_req_ready_i;
    logic            mem_req_we_o;
    logic [XLEN-1:0] mem_req_addr_o;
    inst_size_t      mem_req_size_o;
    logic [XLEN-1:0] mem_req_wdata_o;
    logic            mem_rsp_valid_i;
    logic [XLEN-1:0] mem_rsp_data_i;
    logic            ld_rsp_valid_o;
    lsu_tag_t        ld_rsp_tag_o;
    logic [XLEN-1:0] ld_rsp_data_o;
    logic            idle_o;
    logic            err_o;

    int total = 0;
    int bad   = 0;

    dcache_req_arbiter #(
        .MAX_OUTSTANDING (4),
        .STARVE_MAX      (8)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ld_req_valid_i  (ld_req_valid_i),
        .ld_req_ready_o  (ld_req_ready_o),
        .ld_req_addr_i   (ld_req_addr_i),
        .ld_req_size_i   (ld_req_size_i),
        .ld_req_tag_i    (ld_req_tag_i),
        .st_req_valid_i  (st_req_valid_i),
        .st_req_ready_o  (st_req_ready_o),
        .st_req_addr_i   (st_req_addr_i),
        .st_req_size_i   (st_req_size_i),
        .st_req_data_i   (st_req_data_i),
        .drain_i         (drain_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_we_o    (mem_req_we_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_size_o  (mem_req_size_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .ld_rsp_valid_o  (ld_rsp_valid_o),
        .ld_rsp_tag_o    (ld_rsp_tag_o),
        .ld_rsp_data_o   (ld_rsp_data_o),
        .idle_o          (idle_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld_v;
        logic [3:0]  ld_tag;
        logic [63:0] ld_addr;
        logic        st_v;
        logic [63:0] st_addr;
        logic [63:0] st_data;
        logic        drain;
        logic        mready;
        logic        rsp_v;
        logic [63:0] rsp_data;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_ld_rdy;
        logic        e_st_rdy;
        logic        e_idle;
        logic        e_mvalid;
        logic        e_we;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic        e_rsp_v;
        logic [3:0]  e_rsp_tag;
        logic [63:0] e_rsp_data;
    } vec_t;

    function automatic stim_t mk(input logic ld_v, input logic [3:0] ld_tag,
                                 input logic [63:0] ld_addr, input logic st_v,
                                 input logic [63:0] st_addr, input logic [63:0] st_data,
                                 input logic drain, input logic mready,
                                 input logic rsp_v, input logic [63:0] rsp_data);
        stim_t s;
        s.ld_v = ld_v;   s.ld_tag = ld_tag;   s.ld_addr = ld_addr;
        s.st_v = st_v;   s.st_addr = st_addr; s.st_data = st_data;
        s.drain = drain; s.mready = mready;
        s.rsp_v = rsp_v; s.rsp_data = rsp_data;
        return s;
    endfunction

    task automatic apply_stimulus(input stim_t s);
        ld_req_valid_i  = s.ld_v;
        ld_req_tag_i    = s.ld_tag;
        ld_req_addr_i   = s.ld_addr;
        ld_req_size_i   = SIZE_W;
        st_req_valid_i  = s.st_v;
        st_req_addr_i   = s.st_addr;
        st_req_data_i   = s.st_data;
        st_req_size_i   = SIZE_DW;
        drain_i         = s.drain;
        mem_req_ready_i = s.mready;
        mem_rsp_valid_i = s.rsp_v;
        mem_rsp_data_i  = s.rsp_data;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle: inputs at posedge+1, readies checked at posedge+2,
    // then advance to just after the next edge for registered checks.
    task automatic step(input string name, input stim_t s, input logic e_ld, input logic e_st);
        apply_stimulus(s);
        #1;
        check_output({name, " ld_ready"}, 64'(ld_req_ready_o), 64'(e_ld));
        check_output({name, " st_ready"}, 64'(st_req_ready_o), 64'(e_st));
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp_tag(input string name, input logic [3:0] tag);
        check_output({name, " rsp_valid"}, 64'(ld_rsp_valid_o), 64'd1);
        check_output({name, " rsp_tag"}, 64'(ld_rsp_tag_o), 64'(tag));
    endtask

    vec_t  vecs [8];
    stim_t nop;

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(nop);
        mem_req_ready_i = 1'b0;
        rstn = 1'b0;

        // Single-cycle vectors: load round trip, store, load after store,
        // load beating a fresh store.
        vecs[0] = '{s: mk(1, 3, 64'h100, 0, 0, 0, 0, 1, 0, 0),
                    e_ld_rdy: 1, e_st_rdy: 0, e_idle: 1, e_mvalid: 1, e_we: 0,
                    e_addr: 64'h100, e_wdata: 0, e_rsp_v: 0, e_rsp_tag: 0, e_rsp_data: 0};
        vecs[1] = '{s: mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hDEAD),
                    e_ld_rdy: 0, e_st_rdy: 0, e_idle: 0, e_mvalid: 0, e_we: 0,
                    e_addr: 0, e_wdata: 0, e_rsp_v: 1, e_rsp_tag: 3, e_rsp_data: 64'hDEAD};
        vecs[2] = '{s: nop,
                    e_ld_rdy: 0, e_st_rdy: 0, e_idle: 1, e_mvalid: 0, e_we: 0,
                    e_addr: 0, e_wdata: 0, e_rsp_v: 0, e_rsp_tag: 0, e_rsp_data: 0};
        vecs[3] = '{s: mk(0, 0, 0, 1, 64'h200, 64'h1234, 0, 1, 0, 0),
                    e_ld_rdy: 0, e_st_rdy: 1, e_idle: 0, e_mvalid: 1, e_we: 1,
                    e_addr: 64'h200, e_wdata: 64'h1234, e_rsp_v: 0, e_rsp_tag: 0, e_rsp_data: 0};
        vecs[4] = '{s: mk(1, 5, 64'h300, 0, 0, 0, 0, 1, 0, 0),
                    e_ld_rdy: 1, e_st_rdy: 0, e_idle: 0, e_mvalid: 1, e_we: 0,
                    e_addr: 64'h300, e_wdata: 0, e_rsp_v: 0, e_rsp_tag: 0, e_rsp_data: 0};
        vecs[5] = '{s: mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hBEEF),
                    e_ld_rdy: 0, e_st_rdy: 0, e_idle: 0, e_mvalid: 0, e_we: 0,
                    e_addr: 0, e_wdata: 0, e_rsp_v: 1, e_rsp_tag: 5, e_rsp_data: 64'hBEEF};
        vecs[6] = '{s: mk(1, 1, 64'h400, 1, 64'h500, 64'h7, 0, 1, 0, 0),
                    e_ld_rdy: 1, e_st_rdy: 0, e_idle: 0, e_mvalid: 1, e_we: 0,
                    e_addr: 64'h400, e_wdata: 0, e_rsp_v: 0, e_rsp_tag: 0, e_rsp_data: 0};
        vecs[7] = '{s: mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h55),
                    e_ld_rdy: 0, e_st_rdy: 0, e_idle: 0, e_mvalid: 0, e_we: 0,
                    e_addr: 0, e_wdata: 0, e_rsp_v: 1, e_rsp_tag: 1, e_rsp_data: 64'h55};

        #2;
        check_output("reset mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        check_output("reset ld_rsp_valid", 64'(ld_rsp_valid_o), 64'd0);
        check_output("reset err", 64'(err_o), 64'd0);
        check_output("reset idle", 64'(idle_o), 64'd1);
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            string n;
            n = $sformatf("vec%0d", i);
            apply_stimulus(vecs[i].s);
            #1;
            check_output({n, " ld_ready"}, 64'(ld_req_ready_o), 64'(vecs[i].e_ld_rdy));
            check_output({n, " st_ready"}, 64'(st_req_ready_o), 64'(vecs[i].e_st_rdy));
            check_output({n, " idle"}, 64'(idle_o), 64'(vecs[i].e_idle));
            @(posedge clk);
            #1;
            check_output({n, " mem_valid"}, 64'(mem_req_valid_o), 64'(vecs[i].e_mvalid));
            if (vecs[i].e_mvalid) begin
                check_output({n, " mem_we"}, 64'(mem_req_we_o), 64'(vecs[i].e_we));
                check_output({n, " mem_addr"}, mem_req_addr_o, vecs[i].e_addr);
                check_output({n, " mem_wdata"}, mem_req_wdata_o, vecs[i].e_wdata);
            end
            check_output({n, " rsp_valid"}, 64'(ld_rsp_valid_o), 64'(vecs[i].e_rsp_v));
            if (vecs[i].e_rsp_v) begin
                check_output({n, " rsp_tag"}, 64'(ld_rsp_tag_o), 64'(vecs[i].e_rsp_tag));
                check_output({n, " rsp_data"}, ld_rsp_data_o, vecs[i].e_rsp_data);
            end
        end

        // Loads beat a waiting store for eight cycles, then the store is forced.
        $display("[TB] store starvation");
        for (int k = 0; k <= 8; k++) begin
            string n;
            n = $sformatf("starve%0d", k);
            step(n, mk(1, 4'(k), 64'h1000 + 64'(k * 8), 1, 64'h2000, 64'hAA, 0, 1,
                       (k >= 1), 64'(k)), (k < 8), (k == 8));
            check_output({n, " mem_we"}, 64'(mem_req_we_o), 64'(k == 8));
            check_output({n, " mem_addr"}, mem_req_addr_o,
                         (k == 8) ? 64'h2000 : 64'h1000 + 64'(k * 8));
            if (k >= 1) check_rsp_tag(n, 4'(k - 1));
        end
        step("starve_clr", mk(1, 9, 64'h1100, 1, 64'h2000, 64'hAA, 0, 1, 0, 0), 1, 0);
        step("starve_rsp", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h99), 0, 0);
        check_rsp_tag("starve_rsp", 9);

        // Back-pressure: store held in the slot while the dcache refuses.
        $display("[TB] back-pressure");
        step("bp_st", mk(0, 0, 0, 1, 64'h300, 64'hCAFE, 0, 0, 0, 0), 0, 1);
        for (int c = 0; c < 5; c++) begin
            string n;
            n = $sformatf("bp%0d", c);
            step(n, mk(1, 2, 64'h40, 1, 64'h308, 64'hF00D, 0, 0, 0, 0), 0, 0);
            check_output({n, " mem_valid"}, 64'(mem_req_valid_o), 64'd1);
            check_output({n, " mem_we"}, 64'(mem_req_we_o), 64'd1);
            check_output({n, " mem_addr"}, mem_req_addr_o, 64'h300);
            check_output({n, " mem_wdata"}, mem_req_wdata_o, 64'hCAFE);
        end
        step("bp_release", mk(1, 2, 64'h40, 1, 64'h308, 64'hF00D, 0, 1, 0, 0), 1, 0);
        check_output("bp_release mem_addr", mem_req_addr_o, 64'h40);
        step("bp_st2", mk(0, 0, 0, 1, 64'h308, 64'hF00D, 0, 1, 1, 64'h22), 0, 1);
        check_rsp_tag("bp_st2", 2);
        check_output("bp_st2 mem_addr", mem_req_addr_o, 64'h308);

        // Outstanding limit: four loads fill it, stores still flow.
        $display("[TB] outstanding limit");
        for (int i = 0; i < 4; i++) begin
            step($sformatf("full%0d", i), mk(1, 4'(4 + i), 64'h500 + 64'(i * 8), 0, 0, 0, 0, 1, 0, 0), 1, 0);
        end
        step("full_st", mk(1, 8, 64'h520, 1, 64'h600, 64'h66, 0, 1, 0, 0), 0, 1);
        check_output("full_st mem_we", 64'(mem_req_we_o), 64'd1);
        step("full_hold", mk(1, 8, 64'h520, 0, 0, 0, 0, 1, 0, 0), 0, 0);
        step("full_rsp", mk(1, 8, 64'h520, 0, 0, 0, 0, 1, 1, 64'h11), 0, 0);
        check_rsp_tag("full_rsp", 4);
        step("full_take", mk(1, 8, 64'h520, 0, 0, 0, 0, 1, 0, 0), 1, 0);
        for (int i = 0; i < 4; i++) begin
            string n;
            n = $sformatf("full_drain%0d", i);
            step(n, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'(i)), 0, 0);
            check_rsp_tag(n, 4'(5 + i));
        end

        // Grant and response in the same cycle leave the count unchanged.
        $display("[TB] same-cycle grant and response");
        step("sc_a", mk(1, 10, 64'h700, 0, 0, 0, 0, 1, 0, 0), 1, 0);
        step("sc_b", mk(1, 11, 64'h708, 0, 0, 0, 0, 1, 0, 0), 1, 0);
        step("sc_both", mk(1, 12, 64'h710, 0, 0, 0, 0, 1, 1, 64'hA0), 1, 0);
        check_rsp_tag("sc_both", 10);
        step("sc_c", mk(1, 13, 64'h718, 0, 0, 0, 0, 1, 0, 0), 1, 0);
        step("sc_d", mk(1, 14, 64'h720, 0, 0, 0, 0, 1, 0, 0), 1, 0);
        step("sc_full", mk(1, 15, 64'h728, 0, 0, 0, 0, 1, 0, 0), 0, 0);
        for (int i = 0; i < 4; i++) begin
            string n;
            n = $sformatf("sc_drain%0d", i);
            step(n, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'(i)), 0, 0);
            check_rsp_tag(n, 4'(11 + i));
        end
        check_output("pre_drain err", 64'(err_o), 64'd0);

        // Drain: stores pass, loads held, then an orphan response.
        $display("[TB] drain and orphan response");
        step("dr_st", mk(1, 1, 64'h800, 1, 64'h900, 64'h77, 1, 1, 0, 0), 0, 1);
        check_output("dr_st mem_we", 64'(mem_req_we_o), 64'd1);
        apply_stimulus(mk(1, 1, 64'h800, 0, 0, 0, 1, 1, 0, 0));
        #1;
        check_output("dr_hold idle", 64'(idle_o), 64'd0);
        step("dr_hold", mk(1, 1, 64'h800, 0, 0, 0, 1, 1, 0, 0), 0, 0);
        check_output("dr_hold mem_valid", 64'(mem_req_valid_o), 64'd0);
        apply_stimulus(mk(1, 1, 64'h800, 0, 0, 0, 1, 1, 1, 64'hBAD));
        #1;
        check_output("dr_idle idle", 64'(idle_o), 64'd1);
        check_output("dr_idle err_before", 64'(err_o), 64'd0);
        step("dr_orphan", mk(1, 1, 64'h800, 0, 0, 0, 1, 1, 1, 64'hBAD), 0, 0);
        check_output("dr_orphan err", 64'(err_o), 64'd1);
        check_output("dr_orphan rsp_valid", 64'(ld_rsp_valid_o), 64'd0);
        step("dr_sticky", nop, 0, 0);
        check_output("dr_sticky err", 64'(err_o), 64'd1);

        // Reset in the middle of a held request drops everything.
        $display("[TB] reset mid-operation");
        step("rst_ld", mk(1, 6, 64'hA00, 0, 0, 0, 0, 0, 0, 0), 1, 0);
        check_output("rst_ld mem_valid", 64'(mem_req_valid_o), 64'd1);
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rstn = 1'b0;
        #1;
        check_output("rst mem_valid", 64'(mem_req_valid_o), 64'd0);
        check_output("rst err", 64'(err_o), 64'd0);
        check_output("rst idle", 64'(idle_o), 64'd1);
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
